// File: rtl/mat_input_loader.sv
// ---------------------------------------------------------------------------
// mat_input_loader
//
// Purpose: copies the first 2^SELECT words of a built-in dual-port ROM into a
// register bank, then reads the bank back as half-words, one per enabled
// cycle. The enable input pauses the sequence at any point.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   enable           run (1) / pause (0)
//   rom_address      address driven to both ROM read ports
//   ram_address      downstream write address (count, zero-extended)
//   count            read-out step counter
//   read_en          bank write strobe
//   bank_select_line [SELECT-1:0] bank being written, [SELECT] bank_full
//   select_line      bank being read out (count[SELECT:1])
//   rom_data_2       ROM port-2 data
//   data_out         registered read-out half-word
// ---------------------------------------------------------------------------
module mat_input_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 4,
    parameter int COUNT_DEPTH = 4,
    parameter int SELECT      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic [MEM_DEPTH-1:0]    rom_address,
    output logic [MEM_DEPTH-1:0]    ram_address,
    output logic [COUNT_DEPTH-1:0]  count,
    output logic                    read_en,
    output logic [SELECT:0]         bank_select_line,
    output logic [SELECT-1:0]       select_line,
    output logic [4*DATA_WIDTH-1:0] rom_data_2,
    output logic [2*DATA_WIDTH-1:0] data_out
);

    localparam int WORD_W = 4 * DATA_WIDTH;
    localparam int HALF_W = 2 * DATA_WIDTH;
    localparam int NBANKS = 1 << SELECT;
    localparam logic [MEM_DEPTH-1:0] LAST_ADDR = MEM_DEPTH'(NBANKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_READ,
        S_DONE
    } state_t;

    // ROM word a holds bytes {4a+3, 4a+2, 4a+1, 4a}, most significant lane first.
    function automatic logic [WORD_W-1:0] rom_word(input logic [MEM_DEPTH-1:0] a);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(4 * int'(a) + k);
        end
        return w;
    endfunction

    state_t                 state_q, state_d;
    logic [MEM_DEPTH-1:0]   rom_addr_q, rom_addr_d;
    logic [COUNT_DEPTH-1:0] count_q, count_d;
    logic                   read_en_q, read_en_d;
    logic [SELECT-1:0]      bank_sel_q, bank_sel_d;
    logic                   bank_full_q, bank_full_d;
    logic [HALF_W-1:0]      data_out_q, data_out_d;
    logic [WORD_W-1:0]      bank_q [NBANKS];
    logic [WORD_W-1:0]      rom1_q, rom2_q;

    // ROM read ports: registered output, deliberately not reset.
    always_ff @(posedge clk) begin
        rom1_q <= rom_word(rom_addr_q);
        rom2_q <= rom_word(rom_addr_q);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        count_d     = count_q;
        read_en_d   = 1'b0;
        bank_sel_d  = bank_sel_q;
        bank_full_d = bank_full_q;
        data_out_d  = data_out_q;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_LOAD;
            end
            S_LOAD: begin
                // The strobe and bank index lag the address by one cycle,
                // matching the ROM read latency.
                read_en_d  = enable;
                bank_sel_d = rom_addr_q[SELECT-1:0];
                if (enable) begin
                    if (rom_addr_q == LAST_ADDR) state_d = S_FLUSH;
                    else                         rom_addr_d = rom_addr_q + 1'b1;
                end
            end
            S_FLUSH: begin
                // The last bank write lands on this cycle's edge.
                bank_full_d = 1'b1;
                state_d     = S_READ;
            end
            S_READ: begin
                if (enable) begin
                    data_out_d = count_q[0] ? bank_q[count_q[SELECT:1]][WORD_W-1:HALF_W]
                                            : bank_q[count_q[SELECT:1]][HALF_W-1:0];
                    if (count_q == '1) state_d = S_DONE;
                    else               count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d     = S_IDLE;
                    rom_addr_d  = '0;
                    count_d     = '0;
                    bank_full_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            count_q     <= '0;
            read_en_q   <= 1'b0;
            bank_sel_q  <= '0;
            bank_full_q <= 1'b0;
            data_out_q  <= '0;
            for (int i = 0; i < NBANKS; i++) bank_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            count_q     <= count_d;
            read_en_q   <= read_en_d;
            bank_sel_q  <= bank_sel_d;
            bank_full_q <= bank_full_d;
            data_out_q  <= data_out_d;
            if (read_en_q) bank_q[bank_sel_q] <= rom1_q;
        end
    end

    assign rom_address      = rom_addr_q;
    assign ram_address      = MEM_DEPTH'(count_q);
    assign count            = count_q;
    assign read_en          = read_en_q;
    assign bank_select_line = {bank_full_q, bank_sel_q};
    assign select_line      = count_q[SELECT:1];
    assign rom_data_2       = rom2_q;
    assign data_out         = data_out_q;

endmodule

// File: tb/tb_mat_input_loader.sv
module tb_mat_input_loader;

    localparam int DW = 8;
    localparam int MD = 4;
    localparam int CD = 4;
    localparam int SL = 3;
    localparam int NB = 1 << SL;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [MD-1:0] rom_address, ram_address;
    logic [CD-1:0] count;
    logic          read_en;
    logic [SL:0]   bank_select_line;
    logic [SL-1:0] select_line;
    logic [31:0]   rom_data_2;
    logic [15:0]   data_out;

    mat_input_loader #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .COUNT_DEPTH(CD), .SELECT(SL)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rom_address(rom_address), .ram_address(ram_address), .count(count),
        .read_en(read_en), .bank_select_line(bank_select_line),
        .select_line(select_line), .rom_data_2(rom_data_2), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; logic [31:0] word; } wr_t;
    typedef struct { logic [15:0] val; int cnt; } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;
    logic [15:0] last_dout = '0;

    // Reference ROM: word a has byte lanes 4a..4a+3, lowest in the low lane.
    function automatic logic [31:0] model_word(input int a);
        return {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Expected activity for one full load + read-out pass.
    task automatic push_expected();
        wr_t w;
        rd_t r;
        logic [31:0] wd;
        for (int b = 0; b < NB; b++) begin
            w.idx = b; w.word = model_word(b);
            wq.push_back(w);
        end
        for (int k = 0; k < 2*NB; k++) begin
            wd = model_word(k / 2);
            r.val = (k % 2 == 1) ? wd[31:16] : wd[15:0];
            r.cnt = (k + 1 > 2*NB - 1) ? 2*NB - 1 : k + 1;
            rq.push_back(r);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rom_address"}, 64'(rom_address), 64'd0);
        chk({tag, "_ram_address"}, 64'(ram_address), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_read_en"}, 64'(read_en), 64'd0);
        chk({tag, "_bank_select_line"}, 64'(bank_select_line), 64'd0);
        chk({tag, "_select_line"}, 64'(select_line), 64'd0);
        chk({tag, "_data_out"}, 64'(data_out), 64'd0);
    endtask

    // Monitor: every write strobe and every read-out update is matched
    // against the next expected entry.
    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        if (reset) begin
            if (read_en) begin
                if (wq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_write: bank %0d, nothing expected", bank_select_line[SL-1:0]);
                end else begin
                    w = wq.pop_front();
                    chk("write_bank", 64'(bank_select_line[SL-1:0]), 64'(w.idx));
                    chk("write_full_flag", 64'(bank_select_line[SL]), 64'd0);
                    chk("rom_data_2", 64'(rom_data_2), 64'(w.word));
                end
            end
            if (data_out !== last_dout) begin
                if (rq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_read: data_out 0x%0h, nothing expected", data_out);
                end else begin
                    r = rq.pop_front();
                    chk("data_out", 64'(data_out), 64'(r.val));
                    chk("read_count", 64'(count), 64'(r.cnt));
                    chk("ram_address", 64'(ram_address), 64'(r.cnt));
                    chk("select_line", 64'(select_line), 64'(r.cnt / 2));
                    chk("bank_full", 64'(bank_select_line[SL]), 64'd1);
                end
            end
        end
        last_dout = data_out;
    end

    // mode 0: enable held high; 1: random enable; 2: 3-cycle pause at
    // address 4; 3: reset asserted in READ when count reaches 6.
    task automatic run_seq(input int mode);
        int cyc;
        int pause_left;
        bit paused;
        cyc = 0; pause_left = 0; paused = 0;
        push_expected();
        enable = 1'b1;
        while (cyc < 400 && (wq.size() > 0 || rq.size() > 0)) begin
            @(negedge clk); #1;
            cyc++;
            if (mode == 0 && cyc <= NB) chk("load_address", 64'(rom_address), 64'(cyc - 1));
            if (mode == 3 && count == 6) begin
                #1 reset = 1'b0;
                #1 check_zero("async_reset");
                wq.delete();
                rq.delete();
                for (int i = 0; i < NB; i++) chk("bank_cleared", 64'(dut.bank_q[i]), 64'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk); #1 enable = ~enable;
                end
                check_zero("reset_held");
                enable = 1'b0;
                reset = 1'b1;
                @(negedge clk); #1;
                return;
            end
            case (mode)
                1: enable = ($urandom_range(0, 3) != 0);
                2: begin
                    if (pause_left > 0) begin
                        chk("pause_address", 64'(rom_address), 64'd4);
                        chk("pause_read_en", 64'(read_en), 64'd0);
                        pause_left--;
                        enable = (pause_left == 0);
                    end else if (!paused && rom_address == 4) begin
                        paused = 1;
                        pause_left = 3;
                        enable = 1'b0;
                    end else begin
                        enable = 1'b1;
                    end
                end
                default: enable = 1'b1;
            endcase
        end
        if (cyc >= 400) begin
            total_cnt++;
            $display("FAIL timeout: %0d writes and %0d reads outstanding", wq.size(), rq.size());
            wq.delete();
            rq.delete();
        end
        chk("done_count", 64'(count), 64'(2*NB - 1));
        chk("done_bank_full", 64'(bank_select_line[SL]), 64'd1);
        chk("done_rom_address", 64'(rom_address), 64'(NB - 1));
        chk("done_data_out", 64'(data_out), 64'(model_word(NB - 1) >> 16));
        chk("bank3", 64'(dut.bank_q[3]), 64'(model_word(3)));
        enable = 1'b1;
        @(negedge clk); #1;
        chk("done_hold_count", 64'(count), 64'(2*NB - 1));
        enable = 1'b0;
        @(negedge clk); #1;
        chk("idle_rom_address", 64'(rom_address), 64'd0);
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_bank_full", 64'(bank_select_line[SL]), 64'd0);
        chk("idle_read_en", 64'(read_en), 64'd0);
        chk("idle_bank_kept", 64'(dut.bank_q[5]), 64'(model_word(5)));
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1 enable = ~enable;
        end
        check_zero("reset");
        for (int i = 0; i < NB; i++) chk("reset_bank", 64'(dut.bank_q[i]), 64'd0);
        enable = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;

        run_seq(0);
        run_seq(2);
        for (int i = 0; i < 3; i++) run_seq(1);
        run_seq(3);
        run_seq(0);

        chk("writes_outstanding", 64'(wq.size()), 64'd0);
        chk("reads_outstanding", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
